regfile_param: RTL
==================

// Module: regfile_param
// PURPOSE
//  Parametrised control-register file: N_REGS x DATA_W registers on a valid/ready request/response bus.
//  Per-register access types: RW, RO (hardware-owned) and W1C (hardware-set, software-clear).
//  Byte-strobed writes; out-of-range or illegal accesses are flagged.
//  Sits between the CPU-side bus adapter and datapath blocks, which read regs_q directly.
// PARAMETERS
//  N_REGS     8                         number of registers (>=2)
//  DATA_W     32                        register width in bits (multiple of 8)
//  ADDR_W     4                         word-address width (>= $clog2(N_REGS))
//  RESET_VAL  {N_REGS*DATA_W{1'b1}}     flat reset image; reg i = [i*DATA_W +: DATA_W]
//  RO_MASK    '0 (N_REGS bits)          bit i=1: reg i read-only to the bus
//  W1C_MASK   '0 (N_REGS bits)          bit i=1: reg i is W1C (RO_MASK takes precedence)
// PORTS
//  clk        in   1               clock, all logic on posedge
//  rst        in   1               synchronous, active-high reset
//  req_valid  in   1               request valid
//  req_ready  out  1               request accepted when valid&&ready
//  req_write  in   1               1=write, 0=read
//  req_addr   in   ADDR_W          word address (register index)
//  req_wdata  in   DATA_W          write data
//  req_wstrb  in   DATA_W/8        byte write enables
//  rsp_valid  out  1               response valid
//  rsp_ready  in   1               response consumed when valid&&ready
//  rsp_rdata  out  DATA_W          read data (0 for writes and errors)
//  rsp_err    out  1               1 = address >= N_REGS, or write to an RO reg
//  hw_wen     in   N_REGS          per-register hardware update strobe
//  hw_wdata   in   N_REGS*DATA_W   hardware update data, flat
//  regs_q     out  N_REGS*DATA_W   current value of all registers, flat
// BEHAVIOUR
//  - Reset (rst=1 at posedge): regs<=RESET_VAL, state=IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0.
//    An in-flight response is dropped; the request presented in that cycle is ignored.
//  - FSM IDLE->RESP on accept; RESP->IDLE on rsp_ready. req_ready = (state==IDLE).
//    rsp_valid = (state==RESP). At most one transaction outstanding.
//  - Latency: the response is valid the cycle after acceptance.
//    rsp_* is held stable until rsp_ready; next accept is possible the cycle after handshake.
//  - Read: rsp_rdata = reg value before the accept edge (hw update at the same edge not visible).
//  - Write: applied at the accept edge.
//    RW: bytes with wstrb=1 take wdata.
//    W1C: bits where wdata=1 within strobed bytes are cleared.
//    RO: no change, rsp_err=1.
//  - Address >= N_REGS (full ADDR_W compare, no aliasing): no state change, rsp_err=1, rdata=0.
//  - hw_wen[i] on RW/RO reg: reg <= hw_wdata slice. hw_wen[i] on W1C reg: reg <= reg | slice.
//  - Simultaneous bus write and hw_wen, same reg:
//    RW: bus write wins per strobed byte, hw data fills the other bytes.
//    W1C: next = (q & ~clr) | set, so set wins.
//  - regs_q is driven directly from the register flops (no extra latency after the update edge).
// TESTING
//  1. Release rst; read addr 0..7 -> rsp_rdata=32'hFFFF_FFFF, rsp_err=0, each 1 cycle after accept.
//  2. Write addr 2, wdata 32'h1234_5678, wstrb 4'b0101; read 2 -> 32'hFF34_FF78.
//  3. Read/write addr 8 and 15 -> rsp_err=1, rdata=0, regs_q unchanged (no alias to 0/7).
//  4. RO_MASK[3]=1: write addr 3 -> rsp_err=1, reg unchanged; hw_wen[3] with 32'hA5 -> read 3 = 32'hA5.
//  5. W1C_MASK[4]=1, reset 0: hw set 32'h0F; then bus write 32'h03 in the same cycle as hw set 32'h10
//     -> reg = 32'h1C.
//  6. Hold rsp_ready=0 for 5 cycles: rsp stable, req_ready=0. Assert rst mid-hold -> rsp_valid=0
//     next cycle, regs back to RESET_VAL.

Source files
------------

// File: rtl/regfile_param.sv
// Parametrised control-register file with RW, RO and W1C registers behind a
// single-outstanding valid/ready request/response bus.
module regfile_param #(
  parameter int unsigned               N_REGS    = 8,
  parameter int unsigned               DATA_W    = 32,
  parameter int unsigned               ADDR_W    = 4,
  parameter logic [N_REGS*DATA_W-1:0]  RESET_VAL = '1,
  parameter logic [N_REGS-1:0]         RO_MASK   = '0,
  parameter logic [N_REGS-1:0]         W1C_MASK  = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_write,
  input  logic [ADDR_W-1:0]          req_addr,
  input  logic [DATA_W-1:0]          req_wdata,
  input  logic [DATA_W/8-1:0]        req_wstrb,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [DATA_W-1:0]          rsp_rdata,
  output logic                       rsp_err,
  input  logic [N_REGS-1:0]          hw_wen,
  input  logic [N_REGS*DATA_W-1:0]   hw_wdata,
  output logic [N_REGS*DATA_W-1:0]   regs_q
);

  localparam int unsigned STRB_W = DATA_W / 8;

  typedef enum logic {IDLE, RESP} state_t;

  state_t            state;
  logic [DATA_W-1:0] regs   [N_REGS];
  logic [DATA_W-1:0] regs_d [N_REGS];
  logic [31:0]       addr_ext;
  logic              accept;
  logic              addr_ok;
  logic              ro_hit;
  logic [N_REGS-1:0] sel;
  logic [DATA_W-1:0] byte_mask;
  logic [DATA_W-1:0] rd_data;

  assign accept    = req_valid && (state == IDLE);
  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);

  // Full-width compare so addresses beyond N_REGS never alias onto a register.
  assign addr_ext = 32'(req_addr);
  assign addr_ok  = (addr_ext < N_REGS);

  always_comb begin
    sel     = '0;
    rd_data = '0;
    ro_hit  = 1'b0;
    for (int unsigned i = 0; i < N_REGS; i++) begin
      if (addr_ext == i) begin
        sel[i]  = 1'b1;
        rd_data = regs[i];
        ro_hit  = RO_MASK[i];
      end
    end
  end

  always_comb begin
    byte_mask = '0;
    for (int unsigned b = 0; b < STRB_W; b++) begin
      byte_mask[b*8 +: 8] = {8{req_wstrb[b]}};
    end
  end

  // W1C: hardware set is OR-ed in after the clear so a coincident set survives.
  // RW: hardware data forms the base, strobed bus bytes override it.
  always_comb begin
    logic [DATA_W-1:0] hw;
    logic [DATA_W-1:0] base;
    logic [DATA_W-1:0] clr;
    logic              bus_wr;
    hw     = '0;
    base   = '0;
    clr    = '0;
    bus_wr = 1'b0;
    regs_d = regs;
    for (int unsigned i = 0; i < N_REGS; i++) begin
      hw     = hw_wdata[i*DATA_W +: DATA_W];
      bus_wr = accept && req_write && sel[i];
      clr    = bus_wr ? (req_wdata & byte_mask) : '0;
      base   = hw_wen[i] ? hw : regs[i];
      if (RO_MASK[i]) begin
        regs_d[i] = base;
      end else if (W1C_MASK[i]) begin
        regs_d[i] = (regs[i] & ~clr) | (hw_wen[i] ? hw : '0);
      end else begin
        regs_d[i] = bus_wr ? ((req_wdata & byte_mask) | (base & ~byte_mask)) : base;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_REGS; i++) begin
        regs[i] <= RESET_VAL[i*DATA_W +: DATA_W];
      end
      state     <= IDLE;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      regs <= regs_d;
      case (state)
        IDLE: begin
          if (accept) begin
            state     <= RESP;
            rsp_rdata <= (req_write || !addr_ok) ? '0 : rd_data;
            rsp_err   <= !addr_ok || (req_write && ro_hit);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    regs_q = '0;
    for (int unsigned i = 0; i < N_REGS; i++) begin
      regs_q[i*DATA_W +: DATA_W] = regs[i];
    end
  end

endmodule
